line_clear_engine: RTL and testbench
====================================

Name: line_clear_engine

Overview:
- Row-compaction stage between the game board logic and the display/LED path.
- On a `start` pulse it snapshots the locked playfield, removes every completely filled row, and drops all rows above each removed row by one.
- It reports the cleaned board, the number of lines removed by this operation, and a saturating running score.
- It scans one row per clock, so the full Tetris line-clear fits within a few dozen game-clock cycles.

Parameters:
- ROWS, 15, number of playfield rows; row 0 is the top row, row ROWS-1 is the bottom row.
- COLS, 8, number of playfield columns; a row is full when all COLS bits are 1.
- SCORE_W, 16, width of the running score register.

Ports:
- clk  input  1  system clock (the divided game/display clock).
- reset  input  1  one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- board_in  input  ROWS x COLS  locked board snapshot; bit value 1 means the cell is occupied.
- busy  output  1  high in SCAN and DONE.
- done  output  1  single-cycle completion pulse.
- board_out  output  ROWS x COLS  compacted board.
- lines_cleared  output  $clog2(ROWS+1)  lines removed by the last operation.
- score  output  SCORE_W  cumulative score.

Behaviour:
- Reset (reset low, asynchronous) forces the following, immediately and even mid-operation:
  - state = IDLE
  - board_out = 0 and the internal working board = 0
  - row pointer = ROWS-1
  - lines_cleared = 0, score = 0
  - busy = 0, done = 0
- FSM states are IDLE, SCAN and DONE. Outputs are Moore outputs of the state.
- IDLE:
  - busy = 0.
  - If start = 1 at a clock edge: work <= board_in, ptr <= ROWS-1, line counter <= 0, go to SCAN.
  - board_out is not changed while in IDLE.
- SCAN (one edge per step):
  - If work[ptr] is full:
    - rows 1..ptr take the old contents of rows 0..ptr-1;
    - row 0 becomes all zeros;
    - line counter increments;
    - ptr is unchanged, so the row that dropped into ptr is re-examined next cycle.
  - Else if ptr == 0: go to DONE.
  - Else: ptr <= ptr-1.
- Edge leaving SCAN (into DONE):
  - board_out <= final work;
  - lines_cleared <= count;
  - score <= min(score + pts(count), 2^SCORE_W-1).
- DONE:
  - done = 1 and busy = 1 for exactly one cycle, then IDLE.
- Latency: with the start edge counted as edge 0 and L lines removed, SCAN takes ROWS+L edges. done is high in the cycle following edge ROWS+L.
- Points table pts(n): 0→0, 1→1, 2→3, 3→5, 4→8, n≥5→8+2*(n-4).
  - Arithmetic is done at SCORE_W+1 bits, then saturated.
- A full row 0 is cleared to zero, re-examined, found empty, and the FSM goes to DONE. The scan therefore always terminates.
- start asserted during SCAN or DONE is ignored; it is not queued.
- board_in changing after the start edge has no effect.
- An all-ones board with ROWS=15 gives lines_cleared = 15, board_out = 0, and done in cycle 31.

Test Plan:
- Empty board, start once → done in cycle 16, lines_cleared = 0, board_out = 0, score = 0, busy high in cycles 1–16.
- Row 14 = 8'hFF, row 13 = 8'h18, all other rows 0 → done in cycle 17, lines_cleared = 1, board_out row 14 = 8'h18, all other rows 0, score = 1.
- Rows 14 and 12 = 8'hFF, row 13 = 8'h81, row 11 = 8'h3C → lines_cleared = 2, row 14 = 8'h81, row 13 = 8'h3C, all other rows 0, score += 3, done in cycle 18.
- Rows 11–14 = 8'hFF, row 10 = 8'h01 → lines_cleared = 4, row 14 = 8'h01, score += 8, done in cycle 20. Then repeat 8200 times with score preloaded near saturation → score holds at 16'hFFFF.
- Pulse start again in cycle 5 of an active scan → no restart; exactly one done pulse, and results match the first request.
- Drive reset low at cycle 8 of a scan → busy, done, score, lines_cleared and board_out read 0 before the next clock edge. After reset is released, a new start completes normally.

Source files
------------

// File: rtl/line_clear_engine.sv
// Row-compaction engine: snapshots the locked playfield, removes every full
// row (dropping the rows above it by one), and reports the compacted board,
// the number of rows removed and a saturating running score.
//
// state  | meaning
// IDLE   | waiting for start; board_out holds the previous result
// SCAN   | one row examined per clock, bottom to top
// DONE   | one-cycle completion pulse, results stable
module line_clear_engine #(
  parameter int ROWS    = 15,
  parameter int COLS    = 8,
  parameter int SCORE_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ROWS-1:0][COLS-1:0]     board_in,
  output logic                          busy,
  output logic                          done,
  output logic [ROWS-1:0][COLS-1:0]     board_out,
  output logic [$clog2(ROWS+1)-1:0]     lines_cleared,
  output logic [SCORE_W-1:0]            score
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t                      state;
  logic [ROWS-1:0][COLS-1:0]   work;
  logic [ROWS-1:0][COLS-1:0]   work_shift;
  logic [PW-1:0]               ptr;
  logic [CW-1:0]               cnt;
  logic                        row_full;
  logic [SCORE_W:0]            pts;
  logic [SCORE_W:0]            score_sum;
  logic [SCORE_W-1:0]          score_next;

  // Row under the pointer is full when every cell is occupied.
  always_comb begin
    row_full = &work[ptr];
  end

  // Drop rows 0..ptr-1 into rows 1..ptr and open an empty row at the top.
  always_comb begin
    work_shift = work;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        work_shift[r] = '0;
      end else if (r <= int'(ptr)) begin
        work_shift[r] = work[r-1];
      end
    end
  end

  // Points for this clear; from 4 lines up the table equals 2*n.
  always_comb begin
    pts = '0;
    case (cnt)
      CW'(0):  pts = (SCORE_W+1)'(0);
      CW'(1):  pts = (SCORE_W+1)'(1);
      CW'(2):  pts = (SCORE_W+1)'(3);
      CW'(3):  pts = (SCORE_W+1)'(5);
      default: pts = (SCORE_W+1)'(cnt) << 1;
    endcase
  end

  // Add with one guard bit, then clamp to all-ones on overflow.
  always_comb begin
    score_sum  = {1'b0, score} + pts;
    score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  // Control FSM with registered Moore outputs and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      work          <= '0;
      board_out     <= '0;
      ptr           <= PW'(ROWS - 1);
      cnt           <= '0;
      lines_cleared <= '0;
      score         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            work  <= board_in;
            ptr   <= PW'(ROWS - 1);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            // ptr stays put so the row that just dropped in is re-examined
            work <= work_shift;
            cnt  <= cnt + CW'(1);
          end else if (ptr == '0) begin
            board_out     <= work;
            lines_cleared <= cnt;
            score         <= score_next;
            done          <= 1'b1;
            state         <= DONE_S;
          end else begin
            ptr <= ptr - PW'(1);
          end
        end
        DONE_S: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: stimulus pushes expected results
// computed by a row-list reference model; a monitor pops them on done.
module tb_line_clear_engine;

  localparam int ROWS    = 15;
  localparam int COLS    = 8;
  localparam int SCORE_W = 16;
  localparam int CW      = $clog2(ROWS + 1);
  localparam int SAT     = (1 << SCORE_W) - 1;

  typedef logic [ROWS-1:0][COLS-1:0] brd_t;

  typedef struct {
    brd_t   board;
    int     lines;
    int     score;
    longint start_edge;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               start;
  brd_t               board_in;
  logic               busy;
  logic               done;
  brd_t               board_out;
  logic [CW-1:0]      lines_cleared;
  logic [SCORE_W-1:0] score;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     model_score = 0;
  longint cyc = 0;
  int     busy_cnt = 0;
  int     done_cnt = 0;

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .board_in      (board_in),
    .busy          (busy),
    .done          (done),
    .board_out     (board_out),
    .lines_cleared (lines_cleared),
    .score         (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pts(input int n);
    case (n)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 8 + 2 * (n - 4);
    endcase
  endfunction

  // Keep the non-full rows in bottom-to-top order and restack them at the bottom.
  function automatic void model(input brd_t b, output brd_t o, output int n);
    logic [COLS-1:0] kept[$];
    o = '0;
    n = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (b[r] == {COLS{1'b1}}) n++;
      else kept.push_back(b[r]);
    end
    for (int i = 0; i < kept.size(); i++) o[ROWS-1-i] = kept[i];
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("board_out", 128'(board_out), 128'(e.board));
          check("lines_cleared", 128'(lines_cleared), 128'(e.lines));
          check("score", 128'(score), 128'(e.score));
          check("done_latency", 128'(cyc - e.start_edge), 128'(ROWS + e.lines));
          check("busy_cycles", 128'(busy_cnt), 128'(ROWS + e.lines + 1));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of scan cycle 1.
  task automatic issue(input brd_t b);
    brd_t o;
    int n;
    exp_t e;
    logic [127:0] junk;
    model(b, o, n);
    model_score = model_score + pts(n);
    if (model_score > SAT) model_score = SAT;
    e.board = o;
    e.lines = n;
    e.score = model_score;
    e.start_edge = cyc + 1;
    exp_q.push_back(e);
    start = 1'b1;
    board_in = b;
    @(negedge clk);
    start = 1'b0;
    junk = {$urandom, $urandom, $urandom, $urandom};
    board_in = junk[ROWS*COLS-1:0];
  endtask

  task automatic wait_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 128'(k < 200), 128'(1));
    if (k >= 200) exp_q.delete();
    @(negedge clk);
  endtask

  function automatic brd_t rand_board();
    brd_t b;
    for (int r = 0; r < ROWS; r++) begin
      if ($urandom_range(2) == 0) b[r] = {COLS{1'b1}};
      else b[r] = COLS'($urandom);
    end
    return b;
  endfunction

  initial begin
    brd_t b;
    int d0;
    reset = 1'b0;
    start = 1'b0;
    board_in = '0;
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_board", 128'(board_out), 128'(0));
    check("rst_lines", 128'(lines_cleared), 128'(0));
    check("rst_score", 128'(score), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Empty board
    issue('0);
    wait_idle();

    // Single clear
    b = '0; b[14] = 8'hFF; b[13] = 8'h18;
    issue(b);
    wait_idle();

    // Two clears with a gap row
    b = '0; b[14] = 8'hFF; b[12] = 8'hFF; b[13] = 8'h81; b[11] = 8'h3C;
    issue(b);
    wait_idle();

    // Tetris
    b = '0; b[14] = 8'hFF; b[13] = 8'hFF; b[12] = 8'hFF; b[11] = 8'hFF; b[10] = 8'h01;
    issue(b);
    wait_idle();

    // Full top row only
    b = '0; b[0] = 8'hFF; b[14] = 8'h7F;
    issue(b);
    wait_idle();

    // Random boards
    for (int i = 0; i < 40; i++) begin
      issue(rand_board());
      wait_idle();
    end

    // Second start mid-scan must be ignored
    d0 = done_cnt;
    b = '0; b[14] = 8'hFF; b[9] = 8'h42;
    issue(b);
    repeat (4) @(negedge clk);
    start = 1'b1;
    board_in = '1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("single_done", 128'(done_cnt - d0), 128'(1));

    // Async reset in scan cycle 8
    issue('1);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    check("mid_rst_score", 128'(score), 128'(0));
    check("mid_rst_lines", 128'(lines_cleared), 128'(0));
    check("mid_rst_board", 128'(board_out), 128'(0));
    exp_q.delete();
    model_score = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    b = '0; b[14] = 8'hFF; b[13] = 8'h18;
    issue(b);
    wait_idle();

    // Drive score into saturation with all-ones boards (15 lines, 30 points each)
    while (model_score < SAT) begin
      issue('1);
      wait_idle();
    end
    repeat (3) begin
      issue('1);
      wait_idle();
    end
    check("score_saturated", 128'(score), 128'(16'hFFFF));
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
